mips_mem_responder: RTL and testbench
=====================================

# mips_mem_responder

Memory-side counterpart of the single-clock `mips` core. It answers the core's instruction fetch (`pc` → `instr`) and data accesses (`aluout`/`writedata`/`memwrite` → `readdata`). It loads the program through a valid/ready port while holding the core in reset, then detects HALT and freezes the system. It sits between the core and the bench or host, replacing hand-driven `instr`/`readdata` stimulus.

## Interface
- `NOP_WORD`, default 16'h0800: word `{NOP,11'h0}`, served for unloaded addresses and while loading.
- `HALT_OP`, default 5'b11011: opcode in `instr[15:11]` that ends execution.
- `clk`  in  1: single clock, all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `pc`  in  8: instruction address from the core.
- `instr`  out  16: instruction word to the core, combinational.
- `memwrite`  in  1: data write strobe from the core.
- `aluout`  in  16: data address; only `[7:0]` is used.
- `writedata`  in  16: data write value.
- `readdata`  out  16: data read value, combinational.
- `load_valid`  in  1: program word offered.
- `load_data`  in  16: program word.
- `load_last`  in  1: qualifies the final program word.
- `load_ready`  out  1: responder accepts a program word.
- `cpu_reset`  out  1: drives the core's `reset`.
- `halted`  out  1: HALT reached.
- `cycle_count`  out  16: number of RUN cycles executed, saturating.

## Operation
- Storage:
  - `imem`: 256×16, written only in LOAD.
  - `dmem`: 256×16.
  - `load_len`: 9 bits, 0..256.
  - `load_ptr`: 8 bits.
  - Neither array is cleared by reset.
- States: LOAD, RUN, HALTED. Reset enters LOAD with `load_ptr`=0, `load_len`=0, `cycle_count`=0.
- LOAD:
  - `load_ready`=1, `cpu_reset`=1, `instr`=`NOP_WORD`, data writes suppressed.
  - On `load_valid & load_ready`: `imem[load_ptr]`←`load_data`, `load_ptr`+1, `load_len`+1.
  - Go to RUN on an accepted word with `load_last`=1, or on the accepted word at `load_ptr`=255 (256 words loaded; `load_last` is irrelevant there).
  - `load_last` without `load_valid` has no effect. At least one word must be loaded.
- RUN:
  - `cpu_reset`=0, `load_ready`=0; `load_valid` is ignored.
  - `instr` = `imem[pc]` if `pc` < `load_len`, else `NOP_WORD`.
  - `cycle_count` increments each cycle, saturating at 16'hFFFF.
  - If `instr[15:11]`==`HALT_OP`, go to HALTED at the next edge; that cycle is counted.
- HALTED:
  - `halted`=1, `instr`=`{HALT_OP,11'h0}` regardless of `pc`.
  - `dmem` writes suppressed, `cycle_count` frozen, `cpu_reset`=0.
  - Exit only via reset.
- Data memory:
  - `readdata` = `dmem[aluout[7:0]]`, combinational in all states.
  - Write `dmem[aluout[7:0]]`←`writedata` at the edge when `memwrite`=1 and state is RUN.
  - `aluout[15:8]` is ignored, so addresses wrap modulo 256.

## Timing
- Reset values of outputs:
  - `load_ready`=1, `cpu_reset`=1, `halted`=0, `cycle_count`=0.
  - `instr`=16'h0800.
  - `readdata` = current `dmem` contents (undefined until written).
- Load handshake: a word transfers on every edge with `load_valid & load_ready`. Back-to-back transfers are allowed, one word per cycle, with no bubbles.
- `cpu_reset` falls in the cycle after the last accepted word, so the core's first fetch is at `pc`=0 in the first RUN cycle.
- `instr` and `readdata` have zero latency from `pc`/`aluout`.
- Read-during-write to the same address returns the old value in that cycle and the new value from the next cycle.
- HALT fetched in cycle N: `halted`=1 from cycle N+1. A `memwrite` in cycle N is still performed.
- Reset mid-LOAD or mid-RUN: next cycle is LOAD with `load_len`=0. Previously loaded `imem` words are not served until reloaded.
- Reset has priority over a simultaneous load transfer or data write; neither is performed.

## Test plan
- **Load and fetch.** Reset, then load 16'h99C3, 16'h0800, 16'hD800, the last with `load_last`=1 → `load_len`=3, `cpu_reset`=0 next cycle. Then `pc`=0 gives `instr`=16'h99C3 and `pc`=5 gives 16'h0800.
- **Data write and wrap.** In RUN, `memwrite`=1, `aluout`=16'h0012, `writedata`=16'hBEEF → `readdata` is old in that cycle and 16'hBEEF next cycle. `aluout`=16'h0112 also reads 16'hBEEF.
- **Halt.** Program above with `pc` stepping 0,1,2 from the first RUN cycle → `halted`=1 on the 4th RUN-relative cycle and `cycle_count`=3. `instr` stays 16'hD800 for any `pc`; `memwrite`=1 afterwards leaves `dmem` unchanged.
- **Full load.** Load 256 words with `load_last`=0 throughout → RUN after the 256th word, `load_len`=256; `pc`=8'hFF returns the 256th word.
- **Reset mid-load.** Reset after 2 accepted words → LOAD, `load_ptr`=0, `cycle_count`=0, `load_ready`=1. A following single-word load with `load_last` gives `load_len`=1.
- **Load in RUN.** Assert `load_valid`=1 with `load_data`=16'hFFFF during RUN → `load_ready`=0 and the `imem` fetch at `pc`=0 is unchanged.

Source files
------------

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the single-clock mips core. It loads the program
// through a valid/ready port while the core is held in reset, serves
// instruction fetches and data accesses, and freezes the system on HALT.
module mips_mem_responder #(
  parameter logic [15:0] NOP_WORD = 16'h0800,
  parameter logic [4:0]  HALT_OP  = 5'b11011
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  pc,
  output logic [15:0] instr,
  input  logic        memwrite,
  input  logic [15:0] aluout,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        cpu_reset,
  output logic        halted,
  output logic [15:0] cycle_count
);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [15:0] imem [0:255];
  logic [15:0] dmem [0:255];

  logic [8:0]  load_len;
  logic [7:0]  load_ptr;
  logic        load_fire;
  logic        dmem_we;
  logic [7:0]  daddr;
  logic        pc_loaded;
  logic        unused_addr_hi;

  // Count increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] val);
    if (val == 16'hFFFF) begin
      return val;
    end
    return val + 16'd1;
  endfunction

  // Upper address bits are don't-care: data addresses wrap modulo 256.
  assign daddr          = aluout[7:0];
  assign unused_addr_hi = ^aluout[15:8];
  assign pc_loaded      = ({1'b0, pc} < load_len);
  assign readdata       = dmem[daddr];

  // Next-state and per-state outputs; defaults describe the RUN-like idle view.
  always_comb begin
    next_state = state;
    load_ready = 1'b0;
    cpu_reset  = 1'b0;
    halted     = 1'b0;
    instr      = NOP_WORD;
    load_fire  = 1'b0;
    dmem_we    = 1'b0;
    unique case (state)
      ST_LOAD: begin
        load_ready = 1'b1;
        cpu_reset  = 1'b1;
        load_fire  = load_valid;
        // A full 256-word load ends the phase even without load_last.
        if (load_valid && (load_last || (load_ptr == 8'hFF))) begin
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        instr   = pc_loaded ? imem[pc] : NOP_WORD;
        dmem_we = memwrite;
        if (instr[15:11] == HALT_OP) begin
          next_state = ST_HALTED;
        end
      end
      ST_HALTED: begin
        halted = 1'b1;
        instr  = {HALT_OP, 11'h0};
      end
      default: begin
        next_state = ST_LOAD;
      end
    endcase
  end

  // Control state: FSM, load bookkeeping and the RUN-cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_LOAD;
      load_ptr    <= 8'd0;
      load_len    <= 9'd0;
      cycle_count <= 16'd0;
    end else begin
      state <= next_state;
      if (load_fire) begin
        load_ptr <= load_ptr + 8'd1;
        load_len <= load_len + 9'd1;
      end
      if (state == ST_RUN) begin
        cycle_count <= sat_inc(cycle_count);
      end
    end
  end

  // Program store: written only by accepted load words, never cleared.
  always_ff @(posedge clk) begin
    if (!reset && load_fire) begin
      imem[load_ptr] <= load_data;
    end
  end

  // Data store: core writes land only while running, never cleared.
  always_ff @(posedge clk) begin
    if (!reset && dmem_we) begin
      dmem[daddr] <= writedata;
    end
  end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder: load, fetch, data access, halt,
// full-size load, reset during load and load attempts while running.
module tb_mips_mem_responder;

  logic        clk;
  logic        reset;
  logic [7:0]  pc;
  logic [15:0] instr;
  logic        memwrite;
  logic [15:0] aluout;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        cpu_reset;
  logic        halted;
  logic [15:0] cycle_count;

  int checks   = 0;
  int failures = 0;

  mips_mem_responder dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .instr       (instr),
    .memwrite    (memwrite),
    .aluout      (aluout),
    .writedata   (writedata),
    .readdata    (readdata),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .cpu_reset   (cpu_reset),
    .halted      (halted),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Settle combinational outputs after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; pc = 8'd0; memwrite = 1'b0; aluout = 16'd0; writedata = 16'd0;
    load_valid = 1'b0; load_data = 16'd0; load_last = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_load_ready", {15'd0, load_ready}, 16'd1);
    chk("rst_cpu_reset",  {15'd0, cpu_reset},  16'd1);
    chk("rst_halted",     {15'd0, halted},     16'd0);
    chk("rst_cycle_count", cycle_count,        16'd0);
    chk("rst_instr",       instr,              16'h0800);

    // Three-word program
    reset = 1'b0;
    load_valid = 1'b1; load_data = 16'h99C3; load_last = 1'b0;
    tick();
    load_data = 16'h0800;
    tick();
    load_data = 16'hD800; load_last = 1'b1;
    settle();
    chk("load_cpu_reset_before_last", {15'd0, cpu_reset}, 16'd1);
    chk("load_instr_nop_while_loading", instr, 16'h0800);
    tick();
    load_valid = 1'b0; load_last = 1'b0;

    // RUN cycle 1: pc=0, first data write 0x12 <- 1234
    pc = 8'd0; memwrite = 1'b1; aluout = 16'h0012; writedata = 16'h1234;
    settle();
    chk("run_cpu_reset", {15'd0, cpu_reset}, 16'd0);
    chk("run_load_ready", {15'd0, load_ready}, 16'd0);
    chk("fetch_pc0", instr, 16'h99C3);
    chk("run1_count", cycle_count, 16'd0);
    pc = 8'd5;
    settle();
    chk("fetch_pc5_unloaded", instr, 16'h0800);
    pc = 8'd0;
    settle();
    tick();

    // RUN cycle 2: read-during-write returns the old value
    pc = 8'd1; writedata = 16'hBEEF;
    settle();
    chk("fetch_pc1", instr, 16'h0800);
    chk("run2_count", cycle_count, 16'd1);
    chk("rdw_old", readdata, 16'h1234);
    tick();

    // RUN cycle 3: HALT fetched; write in this cycle still lands
    pc = 8'd2; memwrite = 1'b0; aluout = 16'h0012;
    settle();
    chk("write_new", readdata, 16'hBEEF);
    aluout = 16'h0112;
    settle();
    chk("addr_wrap", readdata, 16'hBEEF);
    chk("fetch_halt", instr, 16'hD800);
    chk("run3_count", cycle_count, 16'd2);
    chk("not_halted_yet", {15'd0, halted}, 16'd0);
    memwrite = 1'b1; aluout = 16'h0013; writedata = 16'hCAFE;
    settle();
    tick();

    // HALTED
    pc = 8'd0; aluout = 16'h0012; writedata = 16'h0000; memwrite = 1'b1;
    settle();
    chk("halted_set", {15'd0, halted}, 16'd1);
    chk("halt_count", cycle_count, 16'd3);
    chk("halt_cpu_reset", {15'd0, cpu_reset}, 16'd0);
    chk("halt_instr_pc0", instr, 16'hD800);
    pc = 8'd77;
    settle();
    chk("halt_instr_pc77", instr, 16'hD800);
    tick();
    memwrite = 1'b0;
    settle();
    chk("halt_write_blocked", readdata, 16'hBEEF);
    aluout = 16'h0013;
    settle();
    chk("halt_cycle_write_done", readdata, 16'hCAFE);
    tick(); tick();
    chk("halt_count_frozen", cycle_count, 16'd3);
    chk("halt_stays", {15'd0, halted}, 16'd1);

    // Full 256-word load, load_last never asserted
    reset = 1'b1; tick(); reset = 1'b0;
    load_last = 1'b1; load_valid = 1'b0;
    tick();
    chk("last_without_valid", {15'd0, load_ready}, 16'd1);
    load_last = 1'b0;
    for (int i = 0; i < 256; i++) begin
      load_valid = 1'b1;
      load_data = {8'hA5, 8'(i)};
      if (i == 255) begin
        settle();
        chk("full_ready_before_256", {15'd0, load_ready}, 16'd1);
      end
      tick();
    end
    load_valid = 1'b0;
    pc = 8'hFF;
    settle();
    chk("full_cpu_reset", {15'd0, cpu_reset}, 16'd0);
    chk("full_fetch_ff", instr, 16'hA5FF);
    pc = 8'h80;
    settle();
    chk("full_fetch_80", instr, 16'hA580);

    // Reset in the middle of a load
    reset = 1'b1; tick(); reset = 1'b0;
    load_valid = 1'b1; load_data = 16'h1111; tick();
    load_data = 16'h2222; tick();
    reset = 1'b1; load_data = 16'h7777; tick();
    reset = 1'b0; load_valid = 1'b0;
    settle();
    chk("midload_ready", {15'd0, load_ready}, 16'd1);
    chk("midload_cpu_reset", {15'd0, cpu_reset}, 16'd1);
    chk("midload_count", cycle_count, 16'd0);
    load_valid = 1'b1; load_data = 16'h3333; load_last = 1'b1;
    tick();
    load_valid = 1'b0; load_last = 1'b0; pc = 8'd0;
    settle();
    chk("single_fetch_pc0", instr, 16'h3333);
    pc = 8'd1;
    settle();
    chk("single_len1_pc1", instr, 16'h0800);

    // Load attempts while running are ignored
    pc = 8'd0; load_valid = 1'b1; load_data = 16'hFFFF; load_last = 1'b1;
    settle();
    chk("run_ignores_load_ready", {15'd0, load_ready}, 16'd0);
    tick(); tick();
    load_valid = 1'b0; load_last = 1'b0;
    settle();
    chk("run_ignores_load_fetch", instr, 16'h3333);
    chk("run_count_after_3", cycle_count, 16'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
